dac_spi_tx: RTL

Serial DAC transmitter at the output end of the sample path. It takes 12-bit filtered samples and a one-cycle valid strobe, and buffers one sample. Each sample is framed with a 4-bit command header and shifted out MSB-first over a 3-wire SPI link (mode 0) to an external 12-bit DAC. It is the output-side counterpart of the ADC-fed filter chain.

---
 rtl/dac_spi_tx_if.sv | 27 ++
 rtl/dac_spi_tx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx_if.sv
// ============================================================================
// dac_spi_tx_if : sample handshake between the filter chain and the DAC link
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface dac_spi_tx_if #(
    parameter int WORD_SIZE = 12
);
    logic [WORD_SIZE-1:0] data_in;
    logic                 data_valid;
    logic                 ready;

    modport master (
        output data_in,
        output data_valid,
        input  ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// dac_spi_tx : one-sample buffer + 16-bit mode-0 SPI framer for a 12-bit DAC
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dac_spi_tx #(
    parameter int         WORD_SIZE = 12,
    parameter logic [3:0] CMD       = 4'b0011,
    parameter int         CLK_DIV   = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    dac_spi_tx_if.slave       smp,
    output logic              sclk,
    output logic              sdata,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int         FRAME_W  = WORD_SIZE + 4;
    localparam int         BIT_W    = $clog2(FRAME_W);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state;
    logic [WORD_SIZE-1:0]   buf_data;
    logic                   ready_r;
    logic [FRAME_W-2:0]     shreg;
    logic [7:0]             div_cnt;
    logic [BIT_W-1:0]       fall_cnt;

    logic                   w_div_end;
    logic                   w_start;
    logic [FRAME_W-1:0]     w_frame;

    assign smp.ready = ready_r;
    assign w_frame   = {CMD, buf_data};
    assign w_div_end = (div_cnt == DIV_LAST);
    // The gap's final edge doubles as an IDLE cycle so back-to-back frames lose nothing.
    assign w_start   = !ready_r && ((state == S_IDLE) || (state == S_GAP && w_div_end));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            buf_data <= '0;
            ready_r  <= 1'b1;
            shreg    <= '0;
            div_cnt  <= '0;
            fall_cnt <= '0;
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;

            if (smp.data_valid) begin
                if (ready_r) begin
                    buf_data <= smp.data_in;
                    ready_r  <= 1'b0;
                end else begin
                    overrun  <= 1'b1;
                end
            end

            if (w_start) begin
                shreg    <= w_frame[FRAME_W-2:0];
                sdata    <= w_frame[FRAME_W-1];
                ready_r  <= 1'b1;
                cs_n     <= 1'b0;
                sclk     <= 1'b0;
                busy     <= 1'b1;
                div_cnt  <= '0;
                fall_cnt <= '0;
                state    <= S_LEAD;
            end else begin
                case (state)
                    S_IDLE: begin
                        cs_n <= 1'b1;
                        sclk <= 1'b0;
                    end
                    S_LEAD: begin
                        if (w_div_end) begin
                            div_cnt <= '0;
                            sclk    <= 1'b1;
                            state   <= S_SHIFT;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    S_SHIFT: begin
                        if (w_div_end) begin
                            div_cnt <= '0;
                            sclk    <= ~sclk;
                            if (sclk) begin
                                if (fall_cnt == BIT_W'(FRAME_W - 1)) begin
                                    state <= S_TRAIL;
                                end else begin
                                    sdata    <= shreg[FRAME_W-2];
                                    shreg    <= shreg << 1;
                                    fall_cnt <= fall_cnt + 1'b1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    S_TRAIL: begin
                        if (w_div_end) begin
                            div_cnt <= '0;
                            cs_n    <= 1'b1;
                            sdata   <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_GAP;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (w_div_end) begin
                            div_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
